// File: rtl/blur_window_feeder.sv
// Row front-end for the 5-tap blur engine: builds a sliding 5-pixel window, issues it to the engine
// and streams back one result per pixel. Define BLUR_EDGE_REPLICATE_EN for clamped edges.
module blur_window_feeder #(
   parameter int unsigned ROW_WIDTH  = 640,
   parameter int unsigned COUNT_BITS = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       in_valid,
   input  logic [7:0] in_pixel,
   output logic       in_ready,
   output logic       blur_en,
   output logic [7:0] blur_pixels [5],
   input  logic       blur_final,
   input  logic [7:0] blur_result,
   output logic       out_valid,
   output logic [7:0] out_pixel,
   input  logic       out_ready,
   output logic       row_done
);

   typedef enum logic [2:0] {
      StIdle, StPrime, StIssue, StWait, StOutput, StFetch, StFlush
   } state_e;

   localparam logic [COUNT_BITS-1:0] RowLen   = COUNT_BITS'(ROW_WIDTH);
   localparam logic [COUNT_BITS-1:0] RowLast  = COUNT_BITS'(ROW_WIDTH - 1);
   localparam logic [COUNT_BITS-1:0] CntOne   = COUNT_BITS'(1);
   localparam logic [COUNT_BITS-1:0] CntPrime = COUNT_BITS'(2);

   state_e                state_q, state_d;
   logic [7:0]            win_q [5];
   logic [7:0]            win_d [5];
   logic [7:0]            win_shift [5];
   logic [COUNT_BITS-1:0] in_cnt_q, in_cnt_d;
   logic [COUNT_BITS-1:0] out_cnt_q, out_cnt_d;
   logic [7:0]            out_pixel_q, out_pixel_d;
   logic [7:0]            fill_pix, edge_pix, shift_in;

`ifdef BLUR_EDGE_REPLICATE_EN
   assign fill_pix = in_pixel;
   assign edge_pix = win_q[4];
`else
   assign fill_pix = 8'd0;
   assign edge_pix = 8'd0;
`endif

   // FLUSH pads past the row end; every other shift takes the incoming pixel.
   assign shift_in = (state_q == StFlush) ? edge_pix : in_pixel;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         win_shift[i] = win_q[i + 1];
      end
      win_shift[4] = shift_in;
   end

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      out_pixel_d = out_pixel_q;
      in_ready    = 1'b0;
      blur_en     = 1'b0;
      out_valid   = 1'b0;
      row_done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               win_d    = '{fill_pix, fill_pix, fill_pix, fill_pix, in_pixel};
               in_cnt_d = CntOne;
               state_d  = StPrime;
            end
         end
         StPrime: begin
            in_ready = 1'b1;
            if (in_valid) begin
               win_d    = win_shift;
               in_cnt_d = in_cnt_q + CntOne;
               if (in_cnt_q == CntPrime) begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            blur_en = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            if (blur_final) begin
               out_pixel_d = blur_result;
               state_d     = StOutput;
            end
         end
         StOutput: begin
            out_valid = 1'b1;
            if (out_ready) begin
               out_cnt_d = out_cnt_q + CntOne;
               if (out_cnt_q == RowLast) begin
                  row_done  = 1'b1;
                  out_cnt_d = '0;
                  in_cnt_d  = '0;
                  state_d   = StIdle;
               end else if (in_cnt_q < RowLen) begin
                  state_d = StFetch;
               end else begin
                  state_d = StFlush;
               end
            end
         end
         StFetch: begin
            in_ready = 1'b1;
            if (in_valid) begin
               win_d    = win_shift;
               in_cnt_d = in_cnt_q + CntOne;
               state_d  = StIssue;
            end
         end
         StFlush: begin
            win_d   = win_shift;
            state_d = StIssue;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         win_q       <= '{default: 8'd0};
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         out_pixel_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         out_pixel_q <= out_pixel_d;
      end
   end

   assign blur_pixels = win_q;
   assign out_pixel   = out_pixel_q;

endmodule
